generic_bus_arbiter_n: RTL and testbench
========================================

Name: generic_bus_arbiter_n

Overview:
- Parametrised N-way arbiter that merges NUM_REQ generic-bus requesters onto one generic-bus memory port.
- Requesters are e.g. I$/D$ memory sides of several harts, or multiple cores in a multicore tile.
- Successor to the fixed two-port cache-to-memory hookup: generalised requester count, selectable round-robin/fixed priority, request buffering, and optional per-requester performance counters.
- Sits between cache memory-side ports and the bus/memory controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- req_ren  in  NUM_REQ  per-requester read request.
- req_wen  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- req_byte_en  in  NUM_REQ*(DATA_W/8)  flattened byte enables.
- req_rdata  out  DATA_W  read data broadcast; valid for the grantee in its completion cycle.
- req_busy  out  NUM_REQ  per-requester busy; low only in that requester's completion cycle.
- mem_ren  out  1  memory read.
- mem_wen  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_byte_en  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data.
- mem_busy  in  1  memory busy; low = transaction completes this cycle.
- grant_id  out  $clog2(NUM_REQ)  current or last grantee.
- arb_active  out  1  high while in BUSY.
- perf_grants  out  NUM_REQ*32  per-requester grant counts (see Optional Feature).
- perf_wait  out  NUM_REQ*32  per-requester wait-cycle counts (see Optional Feature).

Behaviour:
- Clock and reset: single clock CLK. RST is synchronous and active-high; all state is sampled on the CLK rising edge.
- Reset values:
  - state = IDLE.
  - mem_ren = mem_wen = 0; mem_addr, mem_wdata, mem_byte_en = 0.
  - req_busy = all 1; req_rdata = mem_rdata (pass-through).
  - grant_id = 0; arb_active = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
  - Perf counters = 0.
- Request vector: req[i] = req_ren[i] | req_wen[i].
- FSM IDLE:
  - If any req[i], choose winner w.
  - Round-robin: first set bit scanning last+1, last+2, ... modulo NUM_REQ.
  - Fixed priority: lowest set index.
  - At the next edge: state = BUSY, grant_id = w, last = w.
  - At the same edge, latch into output registers: mem_addr/mem_wdata/mem_byte_en from slice w; mem_wen = req_wen[w]; mem_ren = req_ren[w] & ~req_wen[w]. Write wins if both are set.
  - If no request: stay IDLE, outputs unchanged except mem_ren = mem_wen = 0.
- FSM BUSY:
  - Memory outputs held stable from the latch; later changes on requester inputs are ignored.
  - Completion cycle is any BUSY cycle with mem_busy = 0. In that cycle: req_busy[grant_id] = 0 (combinational), req_rdata = mem_rdata.
  - At the edge after completion: state = IDLE, mem_ren = mem_wen = 0.
  - If mem_busy stays 1 indefinitely, remain in BUSY. No timeout.
- Latency:
  - Minimum 2 cycles from request to completion: 1 arbitration cycle plus 1 memory cycle.
  - One IDLE bubble between back-to-back transactions.
  - With round-robin and all requesters active, each requester is served at least once every NUM_REQ transactions.
- Requester contract: hold ren/wen until its busy is seen low, then drop or issue a new request. A request dropped before grant is simply not granted.
- Reset mid-transaction: at the RST edge return to IDLE, deassert mem_ren/mem_wen, and drive all req_busy = 1. The in-flight transaction is abandoned.
- Width rules: grant_id is $clog2(NUM_REQ) bits. Round-robin index arithmetic wraps modulo NUM_REQ, including non-power-of-two values.

Optional Feature:
- Macro: ARB_PERF_COUNTERS_EN.
- Defined:
  - perf_grants[i] increments at each edge where requester i is granted (IDLE to BUSY).
  - perf_wait[i] increments on each cycle where req[i] = 1 and requester i is not the grantee in BUSY. This includes the arbitration cycle and time spent waiting behind others.
  - Both counters are 32-bit and saturate at 32'hFFFF_FFFF.
  - Both clear on RST.
- Undefined: perf_grants and perf_wait are driven constant 0, and no counter flops are instantiated.

Test Plan:
- Single read: NUM_REQ=2, req_ren[1]=1, addr 0x8000_0040, mem_busy=0.
  - Cycle 1: grant_id=1, mem_ren=1, mem_addr=0x8000_0040.
  - Cycle 1: req_busy=2'b01, req_rdata = mem_rdata.
  - Cycle 2: mem_ren=0.
- Round-robin fairness: NUM_REQ=4, all four requesters continuously request, mem_busy=0.
  - Grant sequence is 0,1,2,3,0,... with one IDLE bubble between grants.
  - Each perf_grants = 5 after 20 transactions (ARB_PERF_COUNTERS_EN defined).
- Fixed priority: PRIORITY_MODE=1, requesters 0 and 2 continuously request.
  - Only 0 is granted.
  - perf_wait[2] increments every cycle.
- Long memory stall: mem_busy held 1 for 10 cycles while requester 0 changes req_addr mid-transaction.
  - mem_addr stays at the latched value.
  - req_busy[0]=1 throughout, then 0 in the completion cycle.
- Read/write conflict and write data: requester 1 asserts ren and wen together, wdata 0xDEADBEEF, byte_en 4'b0011.
  - mem_wen=1, mem_ren=0, mem_wdata=0xDEADBEEF, mem_byte_en=4'b0011.
- Reset mid-BUSY: assert RST on the 3rd stall cycle.
  - Next cycle: state IDLE, mem_ren=mem_wen=0, req_busy all 1, grant_id=0.
  - Perf counters 0.
  - After release, requester 0 wins first.

Source files
------------

// File: rtl/generic_bus_arbiter_n.sv
// N-way generic-bus arbiter: round-robin or fixed-priority merge of NUM_REQ requesters onto one memory port.
// Define ARB_PERF_COUNTERS_EN to build the per-requester grant/wait counters; otherwise those outputs are tied to 0.
module generic_bus_arbiter_n #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_REQ-1:0]              req_ren,
  input  logic [NUM_REQ-1:0]              req_wen,
  input  logic [NUM_REQ*ADDR_W-1:0]       req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]       req_wdata,
  input  logic [NUM_REQ*(DATA_W/8)-1:0]   req_byte_en,
  output logic [DATA_W-1:0]               req_rdata,
  output logic [NUM_REQ-1:0]              req_busy,
  output logic                            mem_ren,
  output logic                            mem_wen,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [DATA_W/8-1:0]             mem_byte_en,
  input  logic [DATA_W-1:0]               mem_rdata,
  input  logic                            mem_busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            arb_active,
  output logic [NUM_REQ*32-1:0]           perf_grants,
  output logic [NUM_REQ*32-1:0]           perf_wait
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t            state, state_nxt;
  logic [NUM_REQ-1:0] req;
  logic [ID_W-1:0]   last;
  logic [ID_W-1:0]   win;
  logic              any_req;
  logic              found_hi;
  logic              latch;
  logic              done;

  assign req        = req_ren | req_wen;
  assign req_rdata  = mem_rdata;
  assign arb_active = (state == BUSY);

  // Round-robin: lowest requester above the last grantee, else wrap to lowest overall.
  always_comb begin
    win      = '0;
    any_req  = 1'b0;
    found_hi = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !any_req) begin
        win     = ID_W'(i);
        any_req = 1'b1;
      end
    end
    if (PRIORITY_MODE == 0) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req[i] && !found_hi && (i > 32'(last))) begin
          win      = ID_W'(i);
          found_hi = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = BUSY;
          latch     = 1'b1;
        end
      end
      BUSY: begin
        if (!mem_busy) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_busy = '1;
    if (state == BUSY && !mem_busy) req_busy[grant_id] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_ren     <= 1'b0;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_byte_en <= '0;
      grant_id    <= '0;
      last        <= ID_W'(NUM_REQ - 1);
    end else if (latch) begin
      mem_addr    <= req_addr[win*ADDR_W +: ADDR_W];
      mem_wdata   <= req_wdata[win*DATA_W +: DATA_W];
      mem_byte_en <= req_byte_en[win*BE_W +: BE_W];
      mem_wen     <= req_wen[win];
      mem_ren     <= req_ren[win] & ~req_wen[win];
      grant_id    <= win;
      last        <= win;
    end else if (state == IDLE || done) begin
      mem_ren <= 1'b0;
      mem_wen <= 1'b0;
    end
  end

`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] grants_q [NUM_REQ];
  logic [31:0] wait_q   [NUM_REQ];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        grants_q[i] <= '0;
        wait_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (latch && win == ID_W'(i) && grants_q[i] != '1)
          grants_q[i] <= grants_q[i] + 32'd1;
        if (req[i] && !(state == BUSY && grant_id == ID_W'(i)) && wait_q[i] != '1)
          wait_q[i] <= wait_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    perf_grants = '0;
    perf_wait   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      perf_grants[i*32 +: 32] = grants_q[i];
      perf_wait[i*32 +: 32]   = wait_q[i];
    end
  end
`else
  assign perf_grants = '0;
  assign perf_wait   = '0;
`endif

endmodule

// File: tb/tb_generic_bus_arbiter_n.sv
// Bench for generic_bus_arbiter_n: three instances (4-way round-robin, 4-way fixed priority, 3-way round-robin)
// share stimulus and are compared every cycle against a rule-level reference model.
module tb_generic_bus_arbiter_n;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int NI = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [3:0]      ren, wen;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] wdata;
  logic [4*BW-1:0] be;
  logic [DW-1:0]   mem_rdata;
  logic            mem_busy;

  logic [DW-1:0] rd0, rd1, rd2;
  logic [3:0]    bsy0, bsy1;
  logic [2:0]    bsy2;
  logic          ren0, ren1, ren2, wen0, wen1, wen2, act0, act1, act2;
  logic [AW-1:0] ad0, ad1, ad2;
  logic [DW-1:0] wd0, wd1, wd2;
  logic [BW-1:0] be0, be1, be2;
  logic [1:0]    gid0, gid1, gid2;
  logic [127:0]  pg0, pw0, pg1, pw1;
  logic [95:0]   pg2, pw2;

  generic_bus_arbiter_n #(.NUM_REQ(4), .ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(0)) u_rr4 (
    .CLK(CLK), .RST(RST), .req_ren(ren), .req_wen(wen), .req_addr(addr), .req_wdata(wdata),
    .req_byte_en(be), .req_rdata(rd0), .req_busy(bsy0), .mem_ren(ren0), .mem_wen(wen0),
    .mem_addr(ad0), .mem_wdata(wd0), .mem_byte_en(be0), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .grant_id(gid0), .arb_active(act0), .perf_grants(pg0), .perf_wait(pw0));

  generic_bus_arbiter_n #(.NUM_REQ(4), .ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(1)) u_fp4 (
    .CLK(CLK), .RST(RST), .req_ren(ren), .req_wen(wen), .req_addr(addr), .req_wdata(wdata),
    .req_byte_en(be), .req_rdata(rd1), .req_busy(bsy1), .mem_ren(ren1), .mem_wen(wen1),
    .mem_addr(ad1), .mem_wdata(wd1), .mem_byte_en(be1), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .grant_id(gid1), .arb_active(act1), .perf_grants(pg1), .perf_wait(pw1));

  generic_bus_arbiter_n #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(0)) u_rr3 (
    .CLK(CLK), .RST(RST), .req_ren(ren[2:0]), .req_wen(wen[2:0]), .req_addr(addr[3*AW-1:0]),
    .req_wdata(wdata[3*DW-1:0]), .req_byte_en(be[3*BW-1:0]), .req_rdata(rd2), .req_busy(bsy2),
    .mem_ren(ren2), .mem_wen(wen2), .mem_addr(ad2), .mem_wdata(wd2), .mem_byte_en(be2),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .grant_id(gid2), .arb_active(act2),
    .perf_grants(pg2), .perf_wait(pw2));

  // Reference model state, one slot per instance
  int          nr [NI] = '{4, 4, 3};
  int          pm [NI] = '{0, 1, 0};
  bit          m_busy [NI];
  int          m_gid  [NI];
  int          m_last [NI];
  bit          m_ren  [NI];
  bit          m_wen  [NI];
  logic [31:0] m_addr [NI];
  logic [31:0] m_wdata[NI];
  logic [3:0]  m_be   [NI];
  int unsigned perf_g [NI][4];
  int unsigned perf_w [NI][4];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_busy[k] = 0; m_gid[k] = 0; m_last[k] = nr[k] - 1;
      m_ren[k] = 0; m_wen[k] = 0; m_addr[k] = '0; m_wdata[k] = '0; m_be[k] = '0;
      for (int i = 0; i < 4; i++) begin perf_g[k][i] = 0; perf_w[k][i] = 0; end
    end
  endtask

  task automatic model_advance();
    int n, w, idx;
    if (RST) begin model_reset(); return; end
    for (int k = 0; k < NI; k++) begin
      n = nr[k];
      for (int i = 0; i < n; i++)
        if ((ren[i] | wen[i]) && !(m_busy[k] && m_gid[k] == i) && perf_w[k][i] != 32'hFFFF_FFFF)
          perf_w[k][i]++;
      if (!m_busy[k]) begin
        w = -1;
        if (pm[k] == 1) begin
          for (int i = 0; i < n; i++) if ((ren[i] | wen[i]) && w < 0) w = i;
        end else begin
          for (int j = 1; j <= n; j++) begin
            idx = (m_last[k] + j) % n;
            if ((ren[idx] | wen[idx]) && w < 0) w = idx;
          end
        end
        if (w >= 0) begin
          m_busy[k] = 1; m_gid[k] = w; m_last[k] = w;
          m_addr[k] = addr[w*AW +: AW]; m_wdata[k] = wdata[w*DW +: DW]; m_be[k] = be[w*BW +: BW];
          m_wen[k] = wen[w]; m_ren[k] = ren[w] && !wen[w];
          if (perf_g[k][w] != 32'hFFFF_FFFF) perf_g[k][w]++;
        end else begin
          m_ren[k] = 0; m_wen[k] = 0;
        end
      end else if (!mem_busy) begin
        m_busy[k] = 0; m_ren[k] = 0; m_wen[k] = 0;
      end
    end
  endtask

  task automatic check_inst(input int k, input logic [3:0] busy, input logic [31:0] rd, input logic r,
                            input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b,
                            input logic [1:0] g, input logic act, input logic [127:0] pg, input logic [127:0] pw);
    logic [3:0]   eb;
    logic [127:0] epg, epw;
    eb = '0; epg = '0; epw = '0;
    for (int i = 0; i < nr[k]; i++) eb[i] = 1'b1;
    if (m_busy[k] && !mem_busy) eb[m_gid[k]] = 1'b0;
`ifdef ARB_PERF_COUNTERS_EN
    for (int i = 0; i < nr[k]; i++) begin
      epg[i*32 +: 32] = perf_g[k][i];
      epw[i*32 +: 32] = perf_w[k][i];
    end
`endif
    check($sformatf("u%0d_req_busy", k), busy, eb);
    check($sformatf("u%0d_req_rdata", k), rd, mem_rdata);
    check($sformatf("u%0d_mem_ren", k), r, m_ren[k]);
    check($sformatf("u%0d_mem_wen", k), w, m_wen[k]);
    check($sformatf("u%0d_mem_addr", k), a, m_addr[k]);
    check($sformatf("u%0d_mem_wdata", k), wd, m_wdata[k]);
    check($sformatf("u%0d_mem_byte_en", k), b, m_be[k]);
    check($sformatf("u%0d_grant_id", k), g, m_gid[k]);
    check($sformatf("u%0d_arb_active", k), act, m_busy[k]);
    check($sformatf("u%0d_perf_grants", k), pg, epg);
    check($sformatf("u%0d_perf_wait", k), pw, epw);
  endtask

  // Inputs are set by the caller shortly after a rising edge; outputs are compared mid-cycle.
  task automatic step();
    #2;
    check_inst(0, bsy0, rd0, ren0, wen0, ad0, wd0, be0, gid0, act0, pg0, pw0);
    check_inst(1, bsy1, rd1, ren1, wen1, ad1, wd1, be1, gid1, act1, pg1, pw1);
    check_inst(2, {1'b0, bsy2}, rd2, ren2, wen2, ad2, wd2, be2, gid2, act2, {32'd0, pg2}, {32'd0, pw2});
    model_advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    ren = '0; wen = '0; mem_busy = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  logic [31:0] held_addr;

  initial begin
    ren = '0; wen = '0; addr = '0; wdata = '0; be = '0; mem_rdata = '0; mem_busy = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    do_reset();

    // Single read from requester 1
    ren = 4'b0010; addr[1*AW +: AW] = 32'h8000_0040; mem_rdata = 32'h1234_5678;
    step();
    check("sr_grant_id", gid0, 1);
    check("sr_mem_ren", ren0, 1);
    check("sr_mem_addr", ad0, 32'h8000_0040);
    #1;
    check("sr_req_busy", bsy0, 4'b1101);
    check("sr_req_rdata", rd0, 32'h1234_5678);
    step();
    ren = '0;
    check("sr_ren_drop", ren0, 0);
    step();

    // Round-robin fairness with all four requesting
    do_reset();
    ren = 4'b1111;
    for (int t = 0; t < 20; t++) begin
      step();
      check($sformatf("rr_seq%0d", t), gid0, t % 4);
      check("fp_only0", gid1, 0);
      step();
    end
`ifdef ARB_PERF_COUNTERS_EN
    for (int i = 0; i < 4; i++) check($sformatf("rr_grants%0d", i), pg0[i*32 +: 32], 5);
    check("fp_wait2", pw1[2*32 +: 32], 40);
`endif
    ren = '0;
    step();

    // Long stall while requester 0 changes its address
    do_reset();
    ren = 4'b0001; held_addr = 32'hA5A5_0100; addr[0 +: AW] = held_addr; mem_busy = 1'b1;
    step();
    for (int t = 0; t < 10; t++) begin
      addr[0 +: AW] = $urandom;
      step();
      check("st_mem_addr", ad0, held_addr);
      check("st_busy0", bsy0[0], 1);
    end
    mem_busy = 1'b0;
    #1;
    check("st_done_busy0", bsy0[0], 0);
    step();
    ren = '0;
    step();

    // Read and write together from requester 1
    do_reset();
    ren = 4'b0010; wen = 4'b0010; wdata[1*DW +: DW] = 32'hDEAD_BEEF; be[1*BW +: BW] = 4'b0011;
    step();
    check("rw_mem_wen", wen0, 1);
    check("rw_mem_ren", ren0, 0);
    check("rw_mem_wdata", wd0, 32'hDEAD_BEEF);
    check("rw_mem_byte_en", be0, 4'b0011);
    step();
    ren = '0; wen = '0;
    step();

    // Reset on the third stall cycle
    do_reset();
    ren = 4'b0100; mem_busy = 1'b1;
    step();
    step();
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst_grant_id", gid0, 0);
    check("rst_mem_ren", ren0, 0);
    check("rst_arb_active", act0, 0);
    check("rst_req_busy", bsy0, 4'b1111);
    check("rst_perf", pg0 | pw0, 0);
    ren = 4'b1111; mem_busy = 1'b0;
    step();
    check("rst_first_grant", gid0, 0);
    step();

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          ren[i] = $urandom_range(0, 1) == 1;
          wen[i] = $urandom_range(0, 2) == 0;
        end
        addr[i*AW +: AW]  = $urandom;
        wdata[i*DW +: DW] = $urandom;
        be[i*BW +: BW]    = 4'($urandom);
      end
      mem_busy  = $urandom_range(0, 1) == 1;
      mem_rdata = $urandom;
      RST       = $urandom_range(0, 99) == 0;
      step();
    end
    RST = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
